// File: rtl/aud_player.sv
// I2S playback engine: fetches 16-bit PCM words from the sample buffer and
// shifts each one MSB-first onto AUD_DACDAT for both the left and right channels.
module aud_player #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lrc,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic [ADDR_W-1:0] i_end_addr,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_address,
    input  logic              i_rd_valid,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_dacdat,
    output logic              o_playing,
    output logic              o_done,
    output logic              o_underrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_L,
        S_SHIFT_L,
        S_WAIT_R,
        S_SHIFT_R,
        S_PAUSED
    } state_t;

    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic                rd_req_q,   rd_req_d;
    logic                dacdat_q,   dacdat_d;
    logic                done_q,     done_d;
    logic                underrun_q, underrun_d;
    logic                playing_q,  playing_d;
    logic [DATA_W-1:0]   sample_q,   sample_d;
    logic [DATA_W-1:0]   shift_q,    shift_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                lrc_q,      lrc_d;

    logic lrc_fall;
    logic lrc_rise;
    logic in_play;
    logic shift_last;

    assign lrc_fall   = lrc_q & ~i_lrc;
    assign lrc_rise   = ~lrc_q & i_lrc;
    assign in_play    = state_q inside {S_FETCH, S_WAIT_L, S_SHIFT_L, S_WAIT_R, S_SHIFT_R};
    assign shift_last = (cnt_q == CNT_W'(DATA_W));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_req_d   = rd_req_q;
        dacdat_d   = dacdat_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        sample_d   = sample_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        lrc_d      = i_lrc;

        if (i_stop) begin
            state_d  = S_IDLE;
            addr_d   = '0;
            rd_req_d = 1'b0;
            dacdat_d = 1'b0;
        end else if (i_pause && in_play) begin
            // Address is kept so a resume refetches the interrupted sample.
            state_d  = S_PAUSED;
            rd_req_d = 1'b0;
            dacdat_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_d    = S_FETCH;
                        addr_d     = '0;
                        underrun_d = 1'b0;
                        rd_req_d   = 1'b1;
                    end
                end
                S_PAUSED: begin
                    if (i_start) begin
                        state_d  = S_FETCH;
                        rd_req_d = 1'b1;
                    end
                end
                S_FETCH: begin
                    rd_req_d = 1'b1;
                    if (lrc_fall) begin
                        underrun_d = 1'b1;
                    end
                    if (i_rd_valid && rd_req_q) begin
                        sample_d = i_rd_data;
                        rd_req_d = 1'b0;
                        state_d  = S_WAIT_L;
                    end
                end
                S_WAIT_L: begin
                    // MSB goes out on the BCLK after the LRC transition.
                    if (lrc_fall) begin
                        dacdat_d = sample_q[DATA_W-1];
                        shift_d  = {sample_q[DATA_W-2:0], 1'b0};
                        cnt_d    = CNT_W'(1);
                        state_d  = S_SHIFT_L;
                    end
                end
                S_SHIFT_L: begin
                    if (shift_last) begin
                        dacdat_d = 1'b0;
                        state_d  = S_WAIT_R;
                    end else begin
                        dacdat_d = shift_q[DATA_W-1];
                        shift_d  = {shift_q[DATA_W-2:0], 1'b0};
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
                S_WAIT_R: begin
                    if (lrc_rise) begin
                        dacdat_d = sample_q[DATA_W-1];
                        shift_d  = {sample_q[DATA_W-2:0], 1'b0};
                        cnt_d    = CNT_W'(1);
                        state_d  = S_SHIFT_R;
                    end
                end
                S_SHIFT_R: begin
                    if (shift_last) begin
                        dacdat_d = 1'b0;
                        if (addr_q == i_end_addr) begin
                            done_d  = 1'b1;
                            addr_d  = '0;
                            state_d = S_IDLE;
                        end else begin
                            addr_d   = addr_q + 1'b1;
                            rd_req_d = 1'b1;
                            state_d  = S_FETCH;
                        end
                    end else begin
                        dacdat_d = shift_q[DATA_W-1];
                        shift_d  = {shift_q[DATA_W-2:0], 1'b0};
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    rd_req_d = 1'b0;
                    dacdat_d = 1'b0;
                end
            endcase
        end

        playing_d = state_d inside {S_FETCH, S_WAIT_L, S_SHIFT_L, S_WAIT_R, S_SHIFT_R};
    end

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rd_req_q   <= 1'b0;
            dacdat_q   <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            playing_q  <= 1'b0;
            sample_q   <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
            lrc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_req_q   <= rd_req_d;
            dacdat_q   <= dacdat_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            playing_q  <= playing_d;
            sample_q   <= sample_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            lrc_q      <= lrc_d;
        end
    end

    assign o_rd_req   = rd_req_q;
    assign o_address  = addr_q;
    assign o_dacdat   = dacdat_q;
    assign o_playing  = playing_q;
    assign o_done     = done_q;
    assign o_underrun = underrun_q;

endmodule

// File: tb/tb_aud_player.sv
// Directed bench for aud_player: free-running 64-BCLK LRC, a latency-programmable
// sample memory, and per-scenario tasks with hand-computed expectations.
module tb_aud_player;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    logic              clk;
    logic              i_rst_n;
    logic              i_lrc;
    logic              i_start;
    logic              i_pause;
    logic              i_stop;
    logic [ADDR_W-1:0] i_end_addr;
    logic              o_rd_req;
    logic [ADDR_W-1:0] o_address;
    logic              i_rd_valid;
    logic [DATA_W-1:0] i_rd_data;
    logic              o_dacdat;
    logic              o_playing;
    logic              o_done;
    logic              o_underrun;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:7];
    int          mem_lat = 1;
    int          lat_cnt = 0;
    int          lrc_cnt = 0;

    aud_player #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_lrc      (i_lrc),
        .i_start    (i_start),
        .i_pause    (i_pause),
        .i_stop     (i_stop),
        .i_end_addr (i_end_addr),
        .o_rd_req   (o_rd_req),
        .o_address  (o_address),
        .i_rd_valid (i_rd_valid),
        .i_rd_data  (i_rd_data),
        .o_dacdat   (o_dacdat),
        .o_playing  (o_playing),
        .o_done     (o_done),
        .o_underrun (o_underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // LRC: 32 BCLK high, 32 BCLK low, changed 2 ns after the rising BCLK.
    initial begin
        i_lrc = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            lrc_cnt = (lrc_cnt + 1) % 64;
            i_lrc   = (lrc_cnt >= 32) ? 1'b0 : 1'b1;
        end
    end

    // Sample memory: i_rd_valid rises mem_lat cycles after o_rd_req.
    initial begin
        i_rd_valid = 1'b0;
        i_rd_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (o_rd_req === 1'b1) begin
                lat_cnt = lat_cnt + 1;
                if (lat_cnt >= mem_lat) begin
                    i_rd_valid = 1'b1;
                    i_rd_data  = mem[o_address[2:0]];
                end else begin
                    i_rd_valid = 1'b0;
                end
            end else begin
                lat_cnt    = 0;
                i_rd_valid = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_ctl(input logic s, input logic p, input logic st);
        @(posedge clk);
        #1;
        i_stop  = s;
        i_pause = p;
        i_start = st;
        @(posedge clk);
        #1;
        i_stop  = 1'b0;
        i_pause = 1'b0;
        i_start = 1'b0;
    endtask

    // Returns on the negedge where the requested LRC level change is first visible.
    task automatic wait_lrc(input logic want, output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = i_lrc;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (prev !== want && i_lrc === want) begin
                ok = 1'b1;
                break;
            end
            prev = i_lrc;
        end
    endtask

    task automatic wait_addr(input logic [ADDR_W-1:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (o_address === a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_play(output bit ok);
        wait_lrc(1'b1, ok);
        pulse_ctl(1'b0, 1'b0, 1'b1);
    endtask

    // 32 negedges following an observed LRC edge: 16 data bits, then the idle tail.
    task automatic capture_half(output logic [15:0] word, output int zeros, output int dones);
        word  = '0;
        zeros = 0;
        dones = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i < 16) word = {word[14:0], o_dacdat};
            else if (o_dacdat === 1'b0) zeros = zeros + 1;
            if (o_done === 1'b1) dones = dones + 1;
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if ({o_rd_req, o_dacdat, o_playing, o_done, o_underrun} !== 5'b0) begin
            failures = failures + 1;
            $display("FAIL reset_flags: got %b want 00000",
                     {o_rd_req, o_dacdat, o_playing, o_done, o_underrun});
        end
        checks = checks + 1;
        if (o_address !== '0) begin
            failures = failures + 1;
            $display("FAIL reset_address: got %h want 0", o_address);
        end
        i_rst_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_playback();
        bit          ok;
        logic [15:0] w;
        int          z, d;
        logic [15:0] exp_w [0:3];
        int          exp_d [0:3];
        mem[0] = 16'hA5C3;
        mem[1] = 16'h8001;
        i_end_addr = 1;
        mem_lat = 1;
        exp_w[0] = 16'hA5C3; exp_w[1] = 16'hA5C3; exp_w[2] = 16'h8001; exp_w[3] = 16'h8001;
        exp_d[0] = 0; exp_d[1] = 0; exp_d[2] = 0; exp_d[3] = 1;
        start_play(ok);
        @(negedge clk);
        checks = checks + 1;
        if (o_playing !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL play_started: o_playing got %b want 1", o_playing);
        end
        wait_lrc(1'b0, ok);
        checks = checks + 1;
        if (!ok || o_dacdat !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL play_first_fall: edge_seen %0d dacdat %b want 1/0", ok, o_dacdat);
        end
        for (int h = 0; h < 4; h++) begin
            capture_half(w, z, d);
            checks = checks + 1;
            if (w !== exp_w[h] || z != 16 || d != exp_d[h]) begin
                failures = failures + 1;
                $display("FAIL play_half%0d: word %h zeros %0d done %0d want %h 16 %0d",
                         h, w, z, d, exp_w[h], exp_d[h]);
            end
            if (h == 1) begin
                checks = checks + 1;
                if (o_address !== 20'd1) begin
                    failures = failures + 1;
                    $display("FAIL play_addr_advance: got %h want 1", o_address);
                end
            end
        end
        checks = checks + 1;
        if (o_address !== '0 || o_playing !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL play_end: address %h playing %b want 0 0", o_address, o_playing);
        end
    endtask

    task automatic test_bit_timing();
        bit ok;
        int ones_at_data, zero_tail;
        mem[0] = 16'hFFFF;
        i_end_addr = 0;
        mem_lat = 1;
        start_play(ok);
        wait_lrc(1'b0, ok);
        ones_at_data = 0;
        zero_tail = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i < 16 && o_dacdat === 1'b1) ones_at_data = ones_at_data + 1;
            if (i >= 16 && o_dacdat === 1'b0) zero_tail = zero_tail + 1;
        end
        checks = checks + 1;
        if (!ok || ones_at_data != 16 || zero_tail != 16) begin
            failures = failures + 1;
            $display("FAIL bit_timing: ones %0d tail_zeros %0d want 16 16", ones_at_data, zero_tail);
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        bit ok;
        for (int i = 0; i < 8; i++) mem[i] = 16'h1111 * 16'(i + 1);
        i_end_addr = 7;
        start_play(ok);
        wait_addr(20'd1, ok);
        wait_lrc(1'b0, ok);
        repeat (4) @(negedge clk);
        i_rst_n = 1'b1;
        #1;
        checks = checks + 1;
        if (!ok || {o_rd_req, o_dacdat, o_playing, o_done} !== 4'b0 || o_address !== '0) begin
            failures = failures + 1;
            $display("FAIL rst_mid_shift: reached %0d flags %b address %h want 1 0000 0",
                     ok, {o_rd_req, o_dacdat, o_playing, o_done}, o_address);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks = checks + 1;
        if (o_rd_req !== 1'b0 || o_playing !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL rst_idle: rd_req %b playing %b want 0 0", o_rd_req, o_playing);
        end
        pulse_ctl(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks = checks + 1;
        if (o_rd_req !== 1'b1 || o_address !== '0) begin
            failures = failures + 1;
            $display("FAIL rst_restart: rd_req %b address %h want 1 0", o_rd_req, o_address);
        end
        pulse_ctl(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_pause_resume();
        bit          ok;
        logic [15:0] w;
        int          z, d;
        mem[5] = 16'h5A3C;
        i_end_addr = 7;
        mem_lat = 1;
        start_play(ok);
        wait_addr(20'd5, ok);
        wait_lrc(1'b0, ok);
        repeat (5) @(negedge clk);
        pulse_ctl(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks = checks + 1;
        if (!ok || o_dacdat !== 1'b0 || o_address !== 20'd5 || o_playing !== 1'b0 || o_rd_req !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL pause_enter: reached %0d dacdat %b address %h playing %b rd_req %b want 1 0 5 0 0",
                     ok, o_dacdat, o_address, o_playing, o_rd_req);
        end
        repeat (40) @(negedge clk);
        checks = checks + 1;
        if (o_address !== 20'd5 || o_dacdat !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL pause_hold: address %h dacdat %b want 5 0", o_address, o_dacdat);
        end
        start_play(ok);
        @(negedge clk);
        checks = checks + 1;
        if (o_rd_req !== 1'b1 || o_address !== 20'd5) begin
            failures = failures + 1;
            $display("FAIL pause_resume_fetch: rd_req %b address %h want 1 5", o_rd_req, o_address);
        end
        wait_lrc(1'b0, ok);
        capture_half(w, z, d);
        checks = checks + 1;
        if (!ok || w !== 16'h5A3C || z != 16) begin
            failures = failures + 1;
            $display("FAIL pause_replay: word %h zeros %0d want 5a3c 16", w, z);
        end
        pulse_ctl(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stop_pause();
        bit ok;
        int dones, playing_seen;
        i_end_addr = 7;
        start_play(ok);
        wait_addr(20'd2, ok);
        repeat (3) @(negedge clk);
        pulse_ctl(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks = checks + 1;
        if (!ok || o_address !== '0 || o_playing !== 1'b0 || o_rd_req !== 1'b0 || o_dacdat !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL stop_pause: reached %0d address %h playing %b rd_req %b dacdat %b want 1 0 0 0 0",
                     ok, o_address, o_playing, o_rd_req, o_dacdat);
        end
        dones = 0;
        playing_seen = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (o_done === 1'b1) dones = dones + 1;
            if (o_playing === 1'b1) playing_seen = playing_seen + 1;
        end
        checks = checks + 1;
        if (dones != 0 || playing_seen != 0) begin
            failures = failures + 1;
            $display("FAIL stop_pause_quiet: done %0d playing %0d want 0 0", dones, playing_seen);
        end
    endtask

    task automatic test_underrun();
        bit          ok;
        logic [15:0] w;
        int          z, d;
        mem[0] = 16'h1234;
        i_end_addr = 0;
        mem_lat = 40;
        start_play(ok);
        @(negedge clk);
        checks = checks + 1;
        if (o_underrun !== 1'b0 || o_rd_req !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL underrun_start: underrun %b rd_req %b want 0 1", o_underrun, o_rd_req);
        end
        wait_lrc(1'b0, ok);
        capture_half(w, z, d);
        checks = checks + 1;
        if (!ok || w !== 16'h0000 || z != 16 || o_underrun !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL underrun_frame: word %h zeros %0d underrun %b want 0000 16 1", w, z, o_underrun);
        end
        capture_half(w, z, d);
        checks = checks + 1;
        if (w !== 16'h0000 || z != 16) begin
            failures = failures + 1;
            $display("FAIL underrun_right_silent: word %h zeros %0d want 0000 16", w, z);
        end
        capture_half(w, z, d);
        checks = checks + 1;
        if (w !== 16'h1234 || d != 0) begin
            failures = failures + 1;
            $display("FAIL underrun_next_left: word %h done %0d want 1234 0", w, d);
        end
        capture_half(w, z, d);
        checks = checks + 1;
        if (w !== 16'h1234 || d != 1 || o_underrun !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL underrun_next_right: word %h done %0d underrun %b want 1234 1 1", w, d, o_underrun);
        end
        mem_lat = 1;
        start_play(ok);
        @(negedge clk);
        checks = checks + 1;
        if (o_underrun !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL underrun_clear: got %b want 0", o_underrun);
        end
        pulse_ctl(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        i_rst_n    = 1'b1;
        i_start    = 1'b0;
        i_pause    = 1'b0;
        i_stop     = 1'b0;
        i_end_addr = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        test_reset();
        test_playback();
        test_bit_timing();
        test_reset_mid_shift();
        test_pause_resume();
        test_stop_pause();
        test_underrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aud_player.md
Name: aud_player

Overview:
- Playback counterpart of the audio recorder.
- Reads 16-bit PCM samples from the SRAM sample buffer and serializes them MSB-first to the WM8731 DAC in I2S format.
- Runs in the AUD_BCLK domain. Each sample is sent on both the left and right channels (mono duplication).
- Start/pause/stop controls mirror the recorder's, so the top-level FSM drives both blocks the same way.

Parameters:
ADDR_W, 20, sample address width (SRAM word address)
DATA_W, 16, sample width in bits; also the number of bits shifted per channel

Ports:
i_clk  in  1  AUD_BCLK; all logic on posedge
i_rst_n  in  1  reset, asynchronous, active-high
i_lrc  in  1  AUD_DACLRCK; 1->0 starts the left channel, 0->1 starts the right channel
i_start  in  1  single-cycle pulse; begin playback, or resume from pause
i_pause  in  1  single-cycle pulse; pause playback
i_stop  in  1  single-cycle pulse; abort playback and rewind
i_end_addr  in  ADDR_W  address of the last valid sample (inclusive)
o_rd_req  out  1  memory read request; held high until i_rd_valid
o_address  out  ADDR_W  address of the sample being fetched or played
i_rd_valid  in  1  read data valid; may arrive 1..N cycles after o_rd_req rises
i_rd_data  in  DATA_W  sample word, captured when i_rd_valid=1 and o_rd_req=1
o_dacdat  out  1  AUD_DACDAT serial data
o_playing  out  1  high in FETCH, WAIT_L, SHIFT_L, WAIT_R, SHIFT_R
o_done  out  1  one-cycle pulse when the sample at i_end_addr finishes
o_underrun  out  1  sticky; frame start missed because the sample was not yet fetched

Behaviour:
- Reset values (async): o_address=0, o_rd_req=0, o_dacdat=0, o_done=0, o_underrun=0, o_playing=0, sample register=0, bit counter=0, lrc_p=0, state=IDLE.
- lrc_p is i_lrc registered each cycle.
  - Falling edge: lrc_p=1 and i_lrc=0.
  - Rising edge: lrc_p=0 and i_lrc=1.
- Control priority: i_stop > i_pause > i_start.
  - i_stop in any state: IDLE, o_address<=0, o_rd_req<=0, o_dacdat<=0. No o_done.
  - i_pause in any playing state: PAUSED, o_rd_req<=0, o_dacdat<=0, o_address held. A partially shifted sample is discarded.
  - i_start is ignored while playing.
- IDLE:
  - i_start -> FETCH, o_address<=0, o_underrun<=0.
- PAUSED:
  - i_start -> FETCH with o_address unchanged; the current sample is refetched and replayed from its MSB.
- FETCH:
  - o_rd_req=1 and o_address stable.
  - On i_rd_valid: sample<=i_rd_data, o_rd_req<=0, -> WAIT_L.
  - A falling i_lrc edge seen while in FETCH sets o_underrun<=1. The state stays FETCH and that frame outputs 0.
- WAIT_L:
  - On a falling edge: o_dacdat<=sample[DATA_W-1], bit counter<=1, -> SHIFT_L.
  - This gives a one-BCLK delay after the LRC transition, per I2S.
- SHIFT_L:
  - Each cycle: o_dacdat<=sample[DATA_W-1-cnt], cnt++.
  - When cnt==DATA_W: o_dacdat<=0, -> WAIT_R.
  - Exactly DATA_W bits are driven, then 0 until the next edge.
- WAIT_R / SHIFT_R: identical to WAIT_L / SHIFT_L, triggered by a rising i_lrc edge. SHIFT_R completes as follows:
  - If o_address==i_end_addr: o_done<=1 for one cycle, o_address<=0, -> IDLE.
  - Otherwise: o_address<=o_address+1 (wraps at 2^ADDR_W), -> FETCH.
- An LRC edge arriving mid-shift (BCLK/LRC ratio <2*DATA_W) is ignored. The shift completes normally.
- o_dacdat is 0 whenever not in SHIFT_L/SHIFT_R.
- i_end_addr is sampled continuously; changing it during playback takes effect at the next comparison.
- i_end_addr=0: exactly one sample is played, then o_done.

Test Plan:
- Reset mid-SHIFT_L (rst high 3 cycles) -> all outputs 0, state IDLE; a later i_start fetches address 0.
- Memory {0:16'hA5C3, 1:16'h8001}, i_end_addr=1, 1-cycle read latency, LRC period 64 BCLK -> o_dacdat shows A5C3 MSB-first after LRC fall and after LRC rise, then 8001 twice; o_done pulses once after the last right bit; o_address returns to 0.
- Bit timing -> the MSB appears exactly 1 cycle after the LRC edge is detected; exactly 16 data cycles; o_dacdat=0 for the remaining 16 cycles of each half-frame.
- i_pause during SHIFT_L of address 5 -> o_dacdat=0 and o_address=5 held; i_start -> o_rd_req for address 5; the full sample replays from its MSB at the next LRC fall.
- i_stop and i_pause asserted in the same cycle during playback -> IDLE, o_address=0, o_done stays 0.
- Read latency 40 cycles -> o_underrun=1, that frame outputs all zeros, playback continues with the fetched sample on the following frame; o_underrun clears on the next i_start from IDLE.
